// File: rtl/div_unit.sv
// Multicycle restoring divider producing quotient (lo_out) and remainder (hi_out), one quotient bit per cycle.
// Optional build macro DIV_UNSIGNED_EN adds the div_unsigned input for unsigned (DIVU) operation.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    output logic             busy,
    output logic             div_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dmag;
    logic             neg_q;
    logic             neg_r;

    logic             is_unsigned;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = div_unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    // The magnitude of the most negative operand (2^(WIDTH-1)) is representable as
    // an unsigned WIDTH-bit value, so negation never overflows the datapath.
    always_comb begin
        dvd_neg = ~is_unsigned & dividend[WIDTH-1];
        dvs_neg = ~is_unsigned & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor  : divisor;
    end

    // One restoring step; the partial remainder is widened by one bit for the compare.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, dmag});
        rem_diff = rem_sh[WIDTH-1:0] - dmag;
        rem_nx   = ge ? rem_diff : rem_sh[WIDTH-1:0];
        quo_nx   = {quo[WIDTH-2:0], ge};
        q_fix    = neg_q ? -quo_nx : quo_nx;
        r_fix    = neg_r ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            div_zero <= 1'b0;
                            rem      <= '0;
                            quo      <= dvd_mag;
                            dmag     <= dvs_mag;
                            neg_q    <= dvd_neg ^ dvs_neg;
                            neg_r    <= dvd_neg;
                            cnt      <= CW'(WIDTH);
                            state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    // Final step: results are committed together with the move to DONE.
                    if (cnt == CW'(1)) begin
                        hi_out <= r_fix;
                        lo_out <= q_fix;
                        state  <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign div_done = (state == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed results, divide-by-zero, overflow case, ignored starts, async reset.
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         div_start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         div_unsigned;
    logic         busy;
    logic         div_done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int vectors;
    int miscompares;
    int n;
    int extra;

    div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .dividend     (dividend),
        .divisor      (divisor),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned (div_unsigned),
`endif
        .busy         (busy),
        .div_done     (div_done),
        .div_zero     (div_zero),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!div_done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic uns);
        @(negedge clk);
        dividend     = dvd;
        divisor      = dvs;
        div_unsigned = uns;
        div_start    = 1'b1;
        @(posedge clk);
        #1;
        div_start    = 1'b0;
        dividend     = $urandom;
        divisor      = $urandom;
        div_unsigned = 1'($urandom_range(0, 1));
    endtask

    task automatic do_div(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic uns, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input logic exp_zero, input int exp_lat);
        int cyc;
        pulse_start(dvd, dvs, uns);
        check({name, ".busy_start"}, busy, 1);
        wait_done(80, cyc);
        check({name, ".latency"}, cyc, exp_lat);
        check({name, ".done"}, div_done, 1);
        check({name, ".zero"}, div_zero, exp_zero);
        check({name, ".lo"}, lo_out, exp_lo);
        check({name, ".hi"}, hi_out, exp_hi);
        @(posedge clk);
        #1;
        check({name, ".done_pulse"}, div_done, 0);
        check({name, ".busy_end"}, busy, 0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        div_start    = 1'b0;
        dividend     = '0;
        divisor      = '0;
        div_unsigned = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", div_done, 0);
        check("rst.zero", div_zero, 0);
        check("rst.hi", hi_out, 0);
        check("rst.lo", lo_out, 0);
        @(negedge clk);
        reset = 1'b1;

        do_div("t1", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W);
        do_div("t2a", 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, W);
        do_div("t2b", 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 32'd2, 1'b0, W);
        do_div("t2c", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'd3, 32'hFFFF_FFFF, 1'b0, W);
        do_div("t2d", 32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0, W);
        do_div("t1r", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W);

        // Divide by zero: one busy/done cycle, results held.
        do_div("t3", 32'd5, 32'd0, 1'b0, 32'd14, 32'd2, 1'b1, 0);

        // Overflow case with a second start pulsed mid-calculation.
        pulse_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("t4.zero_cleared", div_zero, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        dividend  = 32'd7;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_done(80, n);
        check("t4.latency", n, W - 6);
        check("t4.lo", lo_out, 32'h8000_0000);
        check("t4.hi", hi_out, 32'd0);
        check("t4.zero", div_zero, 0);

        // Start raised during DONE is ignored, then accepted once IDLE.
        dividend  = 32'd21;
        divisor   = 32'd4;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        check("t4b.ignored_in_done", busy, 0);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        check("t4b.accepted", busy, 1);
        wait_done(80, n);
        check("t4b.latency", n, W);
        check("t4b.lo", lo_out, 32'd5);
        check("t4b.hi", hi_out, 32'd1);

        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done) extra++;
        end
        check("t4.single_done", extra, 0);

        // Async reset in the middle of a division.
        pulse_start(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5.busy", busy, 0);
        check("t5.done", div_done, 0);
        check("t5.zero", div_zero, 0);
        check("t5.hi", hi_out, 0);
        check("t5.lo", lo_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_div("t5r", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, W);

`ifdef DIV_UNSIGNED_EN
        do_div("t6u", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, W);
        do_div("t6s", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, W);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
